// File: rtl/store_packer_pkg.sv
// store_pkg: size encodings, byte-enable masks, buffer entry and occupancy types for store_packer.
package store_pkg;
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    localparam logic [3:0] WE_BYTE = 4'b0001;
    localparam logic [3:0] WE_HALF = 4'b0011;
    localparam logic [3:0] WE_WORD = 4'b1111;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;
endpackage

// File: rtl/store_packer_if.sv
// store_packer_if: store request, memory write beat and fault report signals.
interface store_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [1:0]  in_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        err_pulse;
    logic [31:0] err_addr;

    modport master (
        output in_valid, in_addr, in_data, in_size, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_wdata, mem_we, err_pulse, err_addr
    );
    modport slave (
        input  in_valid, in_addr, in_data, in_size, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_wdata, mem_we, err_pulse, err_addr
    );
endinterface

// File: rtl/store_packer_fifo.sv
// store_fifo: DEPTH-entry write-beat FIFO; occupancy state is derived purely from count.
module store_fifo
    import store_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  entry_t wr_entry,
    output entry_t rd_entry,
    output occ_t   occ
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    // Pointers wrap modulo DEPTH naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign rd_entry = mem[rd_ptr];
    assign occ = count == '0 ? OCC_EMPTY : count == CW'(DEPTH) ? OCC_FULL : OCC_PARTIAL;
endmodule

// File: rtl/store_packer.sv
// store_packer: packs byte/half/word stores into lane-replicated write beats buffered in store_fifo.
// Define STORE_PACKER_ERR_CNT_EN to add a saturating 8-bit err_count output.
module store_packer
    import store_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    store_packer_if.slave bus
`ifdef STORE_PACKER_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);
    entry_t pk, head;
    occ_t   occ;
    size_e  size;
    logic   alive, fault, accept, push, pop;

    assign size = size_e'(bus.in_size);

    always_comb begin
        pk.addr  = bus.in_addr[31:2];
        pk.wdata = size == SIZE_BYTE ? {4{bus.in_data[7:0]}} :
                   size == SIZE_HALF ? {2{bus.in_data[15:0]}} : bus.in_data;
        pk.we    = size == SIZE_BYTE ? WE_BYTE << bus.in_addr[1:0] :
                   size == SIZE_HALF ? (bus.in_addr[1] ? WE_HALF << 2 : WE_HALF) : WE_WORD;
        fault    = (size == SIZE_HALF && bus.in_addr[0]) ||
                   (size == SIZE_WORD && bus.in_addr[1:0] != 2'b00) ||
                   size == SIZE_RSVD;
    end

    // alive holds in_ready low until the first edge after reset release.
    assign bus.in_ready  = alive && occ != OCC_FULL;
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = accept && !fault;
    assign bus.mem_valid = occ != OCC_EMPTY;
    assign pop           = bus.mem_valid && bus.mem_ready;
    assign bus.mem_addr  = bus.mem_valid ? head.addr : '0;
    assign bus.mem_wdata = bus.mem_valid ? head.wdata : '0;
    assign bus.mem_we    = bus.mem_valid ? head.we : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive         <= 1'b0;
            bus.err_pulse <= 1'b0;
            bus.err_addr  <= '0;
        end else begin
            alive         <= 1'b1;
            bus.err_pulse <= accept && fault;
            if (accept && fault) bus.err_addr <= bus.in_addr;
        end
    end

`ifdef STORE_PACKER_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_count <= '0;
        else if (accept && fault && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`endif

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .wr_entry (pk),
        .rd_entry (head),
        .occ      (occ)
    );
endmodule

// File: tb/tb_store_packer.sv
// tb_store_packer: directed self-checking bench for store_packer with DEPTH=2.
module tb_store_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0, errors = 0, beats = 0, pulses = 0, b0 = 0, p0 = 0;

    always #5 clk = ~clk;

    store_packer_if bus();
`ifdef STORE_PACKER_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    store_packer #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef STORE_PACKER_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always @(posedge clk) if (bus.mem_valid && bus.mem_ready) beats++;
    always @(negedge clk) if (bus.err_pulse) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.in_size  = s;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        offer(a, d, s);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_addr = 0; bus.in_data = 0; bus.in_size = 0; bus.mem_ready = 0;
        @(negedge clk);
        check("rst_ready", bus.in_ready, 0);
        check("rst_mvalid", bus.mem_valid, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_pulse", bus.err_pulse, 0);
        check("rst_eaddr", bus.err_addr, 0);
        rst_n = 1'b1;
        #1 check("rel_ready_pre", bus.in_ready, 0);
        @(negedge clk);
        check("rel_ready", bus.in_ready, 1);

        bus.mem_ready = 1;
        store(32'h1003, 32'h0000_00A5, 2'b00);
        check("byte_valid", bus.mem_valid, 1);
        check("byte_addr", bus.mem_addr, 32'h400);
        check("byte_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        check("byte_we", bus.mem_we, 4'b1000);
        @(negedge clk);
        check("idle_valid", bus.mem_valid, 0);
        check("idle_wdata", bus.mem_wdata, 0);
        check("idle_we", bus.mem_we, 0);

        store(32'h2002, 32'h1234_BEEF, 2'b01);
        check("half_addr", bus.mem_addr, 32'h800);
        check("half_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
        check("half_we", bus.mem_we, 4'b1100);
        store(32'h2001, 32'h1234_BEEF, 2'b01);
        check("hfault_pulse", bus.err_pulse, 1);
        check("hfault_eaddr", bus.err_addr, 32'h2001);
        check("hfault_nobeat", bus.mem_valid, 0);
        @(negedge clk);
        check("hfault_once", bus.err_pulse, 0);

        offer(32'h3001, 32'h0, 2'b10);
        @(negedge clk);
        check("b2b_pulse1", bus.err_pulse, 1);
        check("b2b_eaddr1", bus.err_addr, 32'h3001);
        store(32'h4000, 32'h0, 2'b11);
        check("b2b_pulse2", bus.err_pulse, 1);
        check("b2b_eaddr2", bus.err_addr, 32'h4000);
        check("b2b_nobeat", bus.mem_valid, 0);
        @(negedge clk);
        check("b2b_end", bus.err_pulse, 0);

        bus.mem_ready = 0;
        offer(32'h100, 32'h1111_1111, 2'b10);
        check("bp_rdy0", bus.in_ready, 1);
        @(negedge clk);
        offer(32'h104, 32'h2222_2222, 2'b10);
        check("bp_rdy1", bus.in_ready, 1);
        @(negedge clk);
        offer(32'h108, 32'h3333_3333, 2'b10);
        check("bp_rdy2", bus.in_ready, 0);
        check("bp_head_a", bus.mem_addr, 32'h40);
        @(negedge clk);
        check("bp_rdy_stall", bus.in_ready, 0);
        check("bp_stable_addr", bus.mem_addr, 32'h40);
        check("bp_stable_data", bus.mem_wdata, 32'h1111_1111);
        check("bp_stable_we", bus.mem_we, 4'hF);
        bus.mem_ready = 1;
        @(negedge clk);
        check("bp_head_b", bus.mem_addr, 32'h41);
        check("bp_rdy_again", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 0;
        check("bp_head_c", bus.mem_addr, 32'h42);
        check("bp_data_c", bus.mem_wdata, 32'h3333_3333);
        @(negedge clk);
        check("bp_drained", bus.mem_valid, 0);

        b0 = beats;
        for (int i = 0; i <= 10; i++) begin
            offer(32'h8000 + 32'(4 * i), 32'(i), 2'b10);
            @(negedge clk);
            check("pp_valid", bus.mem_valid, 1);
            check("pp_addr", bus.mem_addr, 32'h2000 + 32'(i));
            check("pp_data", bus.mem_wdata, 32'(i));
        end
        bus.in_valid = 0;
        @(negedge clk);
        check("pp_empty", bus.mem_valid, 0);
        check("pp_beats", 32'(beats - b0), 11);

        bus.mem_ready = 0;
        store(32'h200, 32'hAAAA_0001, 2'b10);
        store(32'h204, 32'hAAAA_0002, 2'b10);
        check("mid_full", bus.in_ready, 0);
        check("mid_valid", bus.mem_valid, 1);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_valid", bus.mem_valid, 0);
        check("mid_rst_ready", bus.in_ready, 0);
        check("mid_rst_we", bus.mem_we, 0);
        check("mid_rst_addr", bus.mem_addr, 0);
        b0 = beats;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1;
        @(negedge clk);
        check("mid_rel_ready", bus.in_ready, 1);
        repeat (3) @(negedge clk);
        check("mid_no_beats", 32'(beats - b0), 0);
        check("mid_no_valid", bus.mem_valid, 0);

        offer(32'h5001, 32'h0, 2'b01);
        @(posedge clk);
        #1 bus.in_valid = 0;
        check("rp_pulse", bus.err_pulse, 1);
        rst_n = 1'b0;
        #1 check("rp_cleared", bus.err_pulse, 0);
        check("rp_eaddr", bus.err_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        p0 = pulses;
        offer(32'h6000, 32'h0, 2'b11);
        repeat (260) @(negedge clk);
        bus.in_valid = 0;
        @(negedge clk);
        check("rsvd_pulses", 32'(pulses - p0), 260);
        check("rsvd_eaddr", bus.err_addr, 32'h6000);
        check("rsvd_nobeat", bus.mem_valid, 0);
`ifdef STORE_PACKER_ERR_CNT_EN
        check("rsvd_count", err_count, 8'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
